// File: rtl/regfile_2w2r.sv
// regfile_2w2r: dual-write, dual-read register file with registered reads and same-cycle write bypass
module regfile_2w2r #(
    parameter int DATA_W   = 11,
    parameter int ADDR_W   = 11,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en1,
    input  logic [ADDR_W-1:0] w_adrs1,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              w_en2,
    input  logic [ADDR_W-1:0] w_adrs2,
    input  logic [DATA_W-1:0] data_in2,
    input  logic              r_en1,
    input  logic [ADDR_W-1:0] r_adrs1,
    input  logic              r_en2,
    input  logic [ADDR_W-1:0] r_adrs2,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid1,
    output logic [DATA_W-1:0] data_out2,
    output logic              valid2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout1, r_dout2;
    logic              r_v1, r_v2;
    logic [DATA_W-1:0] w_rd1, w_rd2;
    logic              w_wr1, w_wr2;

    assign w_wr1     = w_en1 && !(ZERO_REG && w_adrs1 == '0);
    assign w_wr2     = w_en2 && !(ZERO_REG && w_adrs2 == '0);
    assign data_out1 = r_dout1;
    assign data_out2 = r_dout2;
    assign valid1    = r_v1;
    assign valid2    = r_v2;

    // read data with bypass: zero register first, then port 2 (the later stage), then port 1, then the array
    always_comb begin
        w_rd1 = (ZERO_REG && r_adrs1 == '0) ? '0 :
                (w_en2 && w_adrs2 == r_adrs1) ? data_in2 :
                (w_en1 && w_adrs1 == r_adrs1) ? data_in1 : r_mem[r_adrs1];
        w_rd2 = (ZERO_REG && r_adrs2 == '0) ? '0 :
                (w_en2 && w_adrs2 == r_adrs2) ? data_in2 :
                (w_en1 && w_adrs1 == r_adrs2) ? data_in1 : r_mem[r_adrs2];
    end

    // array update; port 2 is assigned last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr1) r_mem[w_adrs1] <= data_in1;
            if (w_wr2) r_mem[w_adrs2] <= data_in2;
        end
    end

    // registered read outputs; data holds when the port is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout1 <= '0;
            r_dout2 <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
        end else begin
            r_v1 <= r_en1;
            r_v2 <= r_en2;
            if (r_en1) r_dout1 <= w_rd1;
            if (r_en2) r_dout2 <= w_rd2;
        end
    end
endmodule

// File: tb/tb_regfile_2w2r.sv
// tb_regfile_2w2r: directed table plus randomized checks against a post-write array model, for ZERO_REG = 1 and 0
module tb_regfile_2w2r;
    localparam int DW = 11;
    localparam int AW = 11;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic          rst;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        logic          re1;
        logic [AW-1:0] ra1;
        logic          re2;
        logic [AW-1:0] ra2;
        logic [DW-1:0] d1;
        logic          v1;
        logic [DW-1:0] d2;
        logic          v2;
        logic [DW-1:0] n1;
    } vec_t;

    logic clk = 1'b0;
    logic reset, w_en1, w_en2, r_en1, r_en2;
    logic [AW-1:0] w_adrs1, w_adrs2, r_adrs1, r_adrs2;
    logic [DW-1:0] data_in1, data_in2;
    logic [DW-1:0] z_d1, z_d2, n_d1, n_d2;
    logic z_v1, z_v2, n_v1, n_v2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mz [DEPTH];
    logic [DW-1:0] mn [DEPTH];
    logic [DW-1:0] ez1, ez2, en1, en2;
    logic ev1, ev2;

    vec_t tbl [15];

    always #5 clk = ~clk;

    regfile_2w2r #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_z (
        .clk(clk), .reset(reset),
        .w_en1(w_en1), .w_adrs1(w_adrs1), .data_in1(data_in1),
        .w_en2(w_en2), .w_adrs2(w_adrs2), .data_in2(data_in2),
        .r_en1(r_en1), .r_adrs1(r_adrs1), .r_en2(r_en2), .r_adrs2(r_adrs2),
        .data_out1(z_d1), .valid1(z_v1), .data_out2(z_d2), .valid2(z_v2)
    );

    regfile_2w2r #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_n (
        .clk(clk), .reset(reset),
        .w_en1(w_en1), .w_adrs1(w_adrs1), .data_in1(data_in1),
        .w_en2(w_en2), .w_adrs2(w_adrs2), .data_in2(data_in2),
        .r_en1(r_en1), .r_adrs1(r_adrs1), .r_en2(r_en2), .r_adrs2(r_adrs2),
        .data_out1(n_d1), .valid1(n_v1), .data_out2(n_d2), .valid2(n_v2)
    );

    function automatic vec_t mk(input logic rst, input logic we1, input int wa1, input int wd1,
                                input logic we2, input int wa2, input int wd2,
                                input logic re1, input int ra1, input logic re2, input int ra2,
                                input int d1, input logic v1, input int d2, input logic v2, input int n1);
        vec_t v;
        v.rst = rst; v.we1 = we1; v.wa1 = AW'(wa1); v.wd1 = DW'(wd1);
        v.we2 = we2; v.wa2 = AW'(wa2); v.wd2 = DW'(wd2);
        v.re1 = re1; v.ra1 = AW'(ra1); v.re2 = re2; v.ra2 = AW'(ra2);
        v.d1 = DW'(d1); v.v1 = v1; v.d2 = DW'(d2); v.v2 = v2; v.n1 = DW'(n1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: writes land in order (port 1 then port 2), a read returns the entry's value after this edge's writes;
    // the zero-register model simply never stores anything at address 0
    task automatic model(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mz[i] = '0;
                mn[i] = '0;
            end
            {ez1, ez2, en1, en2, ev1, ev2} = '0;
        end else begin
            if (v.we1) begin
                mn[v.wa1] = v.wd1;
                if (v.wa1 != 0) mz[v.wa1] = v.wd1;
            end
            if (v.we2) begin
                mn[v.wa2] = v.wd2;
                if (v.wa2 != 0) mz[v.wa2] = v.wd2;
            end
            ev1 = v.re1;
            ev2 = v.re2;
            if (v.re1) begin
                ez1 = mz[v.ra1];
                en1 = mn[v.ra1];
            end
            if (v.re2) begin
                ez2 = mz[v.ra2];
                en2 = mn[v.ra2];
            end
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst;
        w_en1 = v.we1; w_adrs1 = v.wa1; data_in1 = v.wd1;
        w_en2 = v.we2; w_adrs2 = v.wa2; data_in2 = v.wd2;
        r_en1 = v.re1; r_adrs1 = v.ra1; r_en2 = v.re2; r_adrs2 = v.ra2;
        @(posedge clk);
        #1;
        model(v);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " z_d1"}, z_d1, ez1);
        chk({tag, " z_v1"}, DW'(z_v1), DW'(ev1));
        chk({tag, " z_d2"}, z_d2, ez2);
        chk({tag, " z_v2"}, DW'(z_v2), DW'(ev2));
        chk({tag, " n_d1"}, n_d1, en1);
        chk({tag, " n_v1"}, DW'(n_v1), DW'(ev1));
        chk({tag, " n_d2"}, n_d2, en2);
        chk({tag, " n_v2"}, DW'(n_v2), DW'(ev2));
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 'h045, 1, 'h7FF, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h045, 1, 'h7FF, 0, 1, 0, 1, 0);
        tbl[3]  = mk(0, 1, 'h045, 'h1A4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h045, 0, 0, 'h1A4, 1, 0, 0, 'h1A4);
        tbl[5]  = mk(0, 1, 'h010, 'h111, 1, 'h010, 'h222, 1, 'h010, 1, 'h010, 'h222, 1, 'h222, 1, 'h222);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h010, 0, 0, 'h222, 1, 'h222, 0, 'h222);
        tbl[7]  = mk(0, 1, 0, 'h3FF, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 'h3FF);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 'h3FF);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h045, 0, 0, 'h1A4, 1, 0, 0, 'h1A4);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1A4, 0, 0, 0, 'h1A4);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1A4, 0, 0, 0, 'h1A4);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1A4, 0, 0, 0, 'h1A4);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 'h045, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h045, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            chk($sformatf("row%0d d1", i), z_d1, tbl[i].d1);
            chk($sformatf("row%0d v1", i), DW'(z_v1), DW'(tbl[i].v1));
            chk($sformatf("row%0d d2", i), z_d2, tbl[i].d2);
            chk($sformatf("row%0d v2", i), DW'(z_v2), DW'(tbl[i].v2));
            chk($sformatf("row%0d nz_d1", i), n_d1, tbl[i].n1);
        end
        apply(mk(0, 0, 0, 0, 1, 'h123, 'h555, 0, 0, 1, 'h123, 0, 0, 0, 0, 0));
        chk("p2 bypass d2", z_d2, 11'h555);
        apply(mk(0, 1, 'h123, 'h0AA, 0, 0, 0, 1, 'h123, 0, 0, 0, 0, 0, 0, 0));
        chk("p1 bypass overwrite d1", z_d1, 11'h0AA);
        chk("p2 hold d2", z_d2, 11'h555);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h123, 0, 0, 0, 0, 0));
        chk("array after overwrite d2", z_d2, 11'h0AA);
        chk_model("seq");
        for (int c = 0; c < 3000; c++) begin
            v.rst = ($urandom_range(0, 199) == 0);
            v.we1 = $urandom_range(0, 1);
            v.we2 = $urandom_range(0, 1);
            v.re1 = $urandom_range(0, 3) != 0;
            v.re2 = $urandom_range(0, 3) != 0;
            v.wa1 = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.wa2 = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.ra1 = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.ra2 = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.wd1 = DW'($urandom);
            v.wd2 = DW'($urandom);
            apply(v);
            chk_model($sformatf("rnd%0d", c));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised register file for the pipelined CPU: two independent write ports, two read ports with registered outputs, and same-cycle write-to-read bypass. It generalises the single-write, dual-read memory used by the decode/writeback stages. Width, depth and the hardwired-zero register are configurable. It sits between writeback, which drives the writes, and decode, which drives the reads.

## Interface
- DATA_W, 11: data width in bits.
- ADDR_W, 11: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: when 1, entry 0 reads as zero and ignores writes.
- clk  input  1  rising-edge clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- w_en1  input  1  write enable, port 1.
- w_adrs1  input  ADDR_W  write address, port 1.
- data_in1  input  DATA_W  write data, port 1.
- w_en2  input  1  write enable, port 2.
- w_adrs2  input  ADDR_W  write address, port 2.
- data_in2  input  DATA_W  write data, port 2.
- r_en1  input  1  read enable, read port 1.
- r_adrs1  input  ADDR_W  read address, read port 1.
- r_en2  input  1  read enable, read port 2.
- r_adrs2  input  ADDR_W  read address, read port 2.
- data_out1  output  DATA_W  registered read data, port 1.
- valid1  output  1  data_out1 updated by a read this cycle.
- data_out2  output  DATA_W  registered read data, port 2.
- valid2  output  1  data_out2 updated by a read this cycle.

## Operation
- Storage: DEPTH x DATA_W array.
- Writes are committed at the rising edge while w_enN is 1.
- Write collision (both w_en high, same address): port 2 data is stored. Port 2 is the later pipeline stage, so it wins.
- Read: at the edge where r_enN = 1, data_outN loads the entry at r_adrsN. validN = 1 for the following cycle.
- Read with r_enN = 0: data_outN holds its previous value; validN = 0.
- Bypass: when a read and a write to the same address occur in the same cycle, data_outN loads the incoming write data, not the old array value.
  - If both writes target that address, port 2 data is bypassed.
  - Bypass applies to each read port independently.
- ZERO_REG = 1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including any bypass case.
- ZERO_REG = 0: address 0 behaves like any other entry.
- reset = 1 at an edge:
  - All array entries clear to 0.
  - data_out1, data_out2, valid1 and valid2 clear to 0.
  - All writes and reads presented that cycle are ignored. Reset has priority over everything.
- Address values are always in range (DEPTH = 2**ADDR_W), so no wrap or out-of-range handling exists.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data valid from edge N until edge N+1.
- Write-to-read through the array: a write at edge N is visible to a read sampled at edge N+1.
- Same-edge write-to-read is covered by the bypass, so effective latency is 0 extra cycles.
- Reset values: every output is 0; every array entry is 0.
- Reset takes effect at the first edge with reset high. Normal operation resumes at the first edge with reset low.
- Reset mid-stream: a read issued in the same cycle as reset produces valid = 0 and data = 0 on the next cycle. There is no stale output.
- No handshake and no back-pressure: every enabled access completes in one cycle.

## Test plan
- Reset then read: assert reset for 2 cycles, then read addresses 0x045 and 0x7FF on both ports -> data_out1 = data_out2 = 0, valid1 = valid2 = 1 one cycle later.
- Write then read: write 0x1A4 to address 0x045 on port 1; next cycle read 0x045 on port 1 -> data_out1 = 0x1A4 after 1 cycle, valid1 = 1.
- Bypass and collision: same cycle, w_en1 writes 0x111 to 0x010, w_en2 writes 0x222 to 0x010, and both read ports read 0x010 -> both outputs = 0x222; a later read of 0x010 also returns 0x222.
- Zero register (ZERO_REG = 1): write 0x3FF to address 0 while reading address 0 -> data_out = 0 at once and on later reads. With ZERO_REG = 0, the same stimulus returns 0x3FF.
- Hold and reset mid-stream:
  - Read 0x045 (value 0x1A4), then drop r_en1 for 3 cycles -> data_out1 holds 0x1A4 and valid1 = 0.
  - Then assert reset together with r_en1 = 1 -> next cycle data_out1 = 0 and valid1 = 0; a later read of 0x045 returns 0.
